test_score: RTL and testbench
=============================

TEST_SCORE -- requirements
Module: test_score

Interface
REQ-001 SHALL have parameter: SCAN_DIV, default 100000, clock cycles each display digit stays lit (minimum 1).
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: enable  input  1  scoring enable; when 0, score updates are ignored.
REQ-005 SHALL have port: player  input  4  one-hot selected player (bit0 = player 1 ... bit3 = player 4).
REQ-006 SHALL have port: ifCorrect  input  1  judge "correct" strobe level; its rising edge awards a point.
REQ-007 SHALL have port: ifWrong  input  1  judge "wrong" strobe level; its rising edge deducts a point.
REQ-008 SHALL have port: seg_out  output  8  active-low segment pattern {dp,g,f,e,d,c,b,a}.
REQ-009 SHALL have port: seg_en  output  8  active-low digit enables; exactly one bit 0 when scanning.
REQ-010 SHALL have port: num  output  4  registered score of the currently selected player.

Function
REQ-011 SHALL keep four 4-bit unsigned scores, one per player, range 0..15.
REQ-012 SHALL register ifCorrect and ifWrong and detect rising edges (current 1, previous 0).
REQ-013 SHALL, on a detected ifCorrect edge with enable=1 and player one-hot, increment that player's score, saturating at 15.
REQ-014 SHALL, on a detected ifWrong edge with enable=1 and player one-hot, decrement that player's score, saturating at 0.
REQ-015 SHALL make no score change when both edges occur in the same cycle.
REQ-016 SHALL ignore edges when enable=0 or player is not one-hot (zero or multiple bits set); edge-detect registers still update.
REQ-017 SHALL update a score one cycle after the edge is registered (two clk edges after the input rises); num reflects the new score one cycle later.
REQ-018 SHALL drive num = score of the one-hot selected player, or 0 when player is not one-hot.
REQ-019 SHALL scan eight digits 0..7 cyclically, advancing every SCAN_DIV cycles; digit 7 wraps to 0.
REQ-020 SHALL map digit 2k to the tens and digit 2k+1 to the ones of player k+1's decimal score (k=0..3); tens digit blank (all segments off) when score < 10.
REQ-021 SHALL encode decimal 0..9 with standard active-low 7-segment patterns, dp always off (e.g. 0 -> 8'hC0, 1 -> 8'hF9, 5 -> 8'h92).
REQ-022 SHALL register seg_out and seg_en together so they always refer to the same digit.

Reset
REQ-023 SHALL, while rst=0 at a clk edge, clear all scores, edge-detect registers, scan counter and digit index to 0.
REQ-024 SHALL drive num=0, seg_en=8'hFF, seg_out=8'hFF during reset; scanning resumes at digit 0 on the first cycle after release.
REQ-025 SHALL honour reset asserted mid-operation identically, discarding any pending edge.

Structure
REQ-026 SHALL place the 7-segment digit patterns and the blank pattern constant in a shared package.
REQ-027 SHALL implement the digit-to-segment decode as one sub-module, seg7_decode (4-bit digit/blank in, 8-bit pattern out, combinational).

Verification
REQ-028 SHALL check reset: rst=0 for 3 cycles -> num=0, seg_en=8'hFF, seg_out=8'hFF, all scores 0.
REQ-029 SHALL check scoring: enable=1, player=4'b0001, three ifCorrect rising edges 5 cycles apart -> num=3; digit 1 shows 8'hB0, digit 0 blank.
REQ-030 SHALL check deduction/saturation: from score 3, one ifWrong edge -> num=2; from 0, ifWrong edge -> num stays 0; 16 ifCorrect edges from 0 -> num=15, digits 0/1 show 8'hF9/8'h92.
REQ-031 SHALL check gating: enable=0 with ifCorrect edges -> no change; player=4'b0011 with edges -> no change and num=0; simultaneous ifCorrect/ifWrong edges -> no change.
REQ-032 SHALL check player switch and scan: after player 1 = 2, switch to player=4'b0010 and give 10 ifCorrect edges -> num=10, player 1 retains 2; with SCAN_DIV=2, seg_en steps FE, FD, ..., 7F, FE every 2 cycles.

Source files
------------

// File: rtl/test_score_pkg.sv
// Shared constants for the four-player score board: 7-segment patterns,
// blank pattern and one-hot player helpers.
package test_score_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
    endfunction

    function automatic logic [1:0] onehot4_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/test_score_seg7_decode.sv
// Combinational decimal-digit to active-low 7-segment pattern decoder.
module seg7_decode
    import test_score_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    // Digit lookup; codes above 9 and an explicit blank request show nothing.
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/test_score.sv
// Four-player quiz score keeper: edge-triggered +1/-1 scoring with saturation
// and an eight-digit multiplexed 7-segment display (tens/ones per player).
module test_score
    import test_score_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] player,
    input  logic       ifCorrect,
    input  logic       ifWrong,
    output logic [7:0] seg_out,
    output logic [7:0] seg_en,
    output logic [3:0] num
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [3:0]       r_score [4];
    logic             r_cor_cur, r_cor_prev, r_wrg_cur, r_wrg_prev;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [2:0]       r_digit;
    logic [7:0]       r_seg_out, r_seg_en;
    logic [3:0]       r_num;

    logic             w_cor_edge, w_wrg_edge, w_player_ok;
    logic [1:0]       w_idx;
    logic [3:0]       w_disp_score, w_dec_digit;
    logic             w_dec_blank;
    logic [7:0]       w_seg;

    assign w_cor_edge  = r_cor_cur & ~r_cor_prev;
    assign w_wrg_edge  = r_wrg_cur & ~r_wrg_prev;
    assign w_player_ok = is_onehot4(player);
    assign w_idx       = onehot4_index(player);

    // Even digits carry the tens (blank below 10), odd digits the ones.
    always_comb begin
        w_disp_score = r_score[r_digit[2:1]];
        w_dec_digit  = 4'd0;
        w_dec_blank  = 1'b0;
        if (r_digit[0]) begin
            w_dec_digit = (w_disp_score >= 4'd10) ? (w_disp_score - 4'd10) : w_disp_score;
            w_dec_blank = 1'b0;
        end else begin
            w_dec_digit = 4'd1;
            w_dec_blank = (w_disp_score < 4'd10);
        end
    end

    seg7_decode u_seg7_decode (
        .i_digit (w_dec_digit),
        .i_blank (w_dec_blank),
        .o_seg   (w_seg)
    );

    // Edge detection and saturating score update; simultaneous edges cancel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cor_cur  <= 1'b0;
            r_cor_prev <= 1'b0;
            r_wrg_cur  <= 1'b0;
            r_wrg_prev <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_score[i] <= 4'd0;
            end
        end else begin
            r_cor_cur  <= ifCorrect;
            r_cor_prev <= r_cor_cur;
            r_wrg_cur  <= ifWrong;
            r_wrg_prev <= r_wrg_cur;
            if (enable && w_player_ok && w_cor_edge && !w_wrg_edge) begin
                if (r_score[w_idx] != 4'd15) begin
                    r_score[w_idx] <= r_score[w_idx] + 4'd1;
                end
            end else if (enable && w_player_ok && w_wrg_edge && !w_cor_edge) begin
                if (r_score[w_idx] != 4'd0) begin
                    r_score[w_idx] <= r_score[w_idx] - 4'd1;
                end
            end
        end
    end

    // Digit scan timing plus registered outputs (seg_en/seg_out sampled from one digit).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 3'd0;
            r_seg_out  <= 8'hFF;
            r_seg_en   <= 8'hFF;
            r_num      <= 4'd0;
        end else begin
            if (r_scan_cnt == CNT_LAST) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            r_seg_en  <= ~(8'd1 << r_digit);
            r_seg_out <= w_seg;
            r_num     <= w_player_ok ? r_score[w_idx] : 4'd0;
        end
    end

    assign seg_out = r_seg_out;
    assign seg_en  = r_seg_en;
    assign num     = r_num;

endmodule

// File: tb/tb_test_score.sv
// Directed self-checking bench for test_score with a fast scan (SCAN_DIV=2).
module tb_test_score;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] player = 4'b0000;
    logic       ifCorrect = 1'b0;
    logic       ifWrong = 1'b0;
    logic [7:0] seg_out, seg_en;
    logic [3:0] num;

    int n_checks = 0;
    int n_errors = 0;

    test_score #(.SCAN_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .player    (player),
        .ifCorrect (ifCorrect),
        .ifWrong   (ifWrong),
        .seg_out   (seg_out),
        .seg_en    (seg_en),
        .num       (num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulses are 2 cycles high, 3 low: 5 cycles apart, long enough for num to settle.
    task automatic pulse(input logic c, input logic w);
        ifCorrect = c;
        ifWrong   = w;
        tick(2);
        ifCorrect = 1'b0;
        ifWrong   = 1'b0;
        tick(3);
    endtask

    task automatic read_digit(input int d, output logic [7:0] seg);
        logic [7:0] want;
        int n;
        want = ~(8'd1 << d);
        n = 0;
        while (seg_en !== want && n < 40) begin
            tick(1);
            n++;
        end
        if (n >= 40) check("scan_timeout", seg_en, want);
        seg = seg_out;
    endtask

    task automatic select(input logic [3:0] p);
        player = p;
        tick(2);
    endtask

    logic [7:0] seg;
    logic [7:0] exp_en;

    initial begin
        tick(3);
        check("rst_num", {4'd0, num}, 8'h00);
        check("rst_seg_en", seg_en, 8'hFF);
        check("rst_seg_out", seg_out, 8'hFF);
        rst = 1'b1;
        tick(1);
        check("scan_start_digit0", seg_en, 8'hFE);
        for (int p = 0; p < 4; p++) begin
            select(4'b0001 << p);
            check("rst_score", {4'd0, num}, 8'h00);
        end

        enable = 1'b1;
        select(4'b0001);
        repeat (3) pulse(1'b1, 1'b0);
        check("score_p1_3", {4'd0, num}, 8'h03);
        read_digit(1, seg); check("p1_ones_3", seg, 8'hB0);
        read_digit(0, seg); check("p1_tens_blank", seg, 8'hFF);

        pulse(1'b0, 1'b1);
        check("deduct_to_2", {4'd0, num}, 8'h02);

        enable = 1'b0;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        enable = 1'b1;
        tick(1);
        check("gate_enable0", {4'd0, num}, 8'h02);

        select(4'b0011);
        pulse(1'b1, 1'b0);
        check("multi_hot_num0", {4'd0, num}, 8'h00);
        select(4'b0000);
        pulse(1'b0, 1'b1);
        check("zero_hot_num0", {4'd0, num}, 8'h00);
        select(4'b0001);
        check("gate_player_unchanged", {4'd0, num}, 8'h02);
        pulse(1'b1, 1'b1);
        check("simultaneous_nochange", {4'd0, num}, 8'h02);

        select(4'b0010);
        repeat (10) pulse(1'b1, 1'b0);
        check("p2_score_10", {4'd0, num}, 8'h0A);
        read_digit(2, seg); check("p2_tens_1", seg, 8'hF9);
        read_digit(3, seg); check("p2_ones_0", seg, 8'hC0);
        read_digit(1, seg); check("p1_ones_2", seg, 8'hA4);
        select(4'b0001);
        check("p1_retains_2", {4'd0, num}, 8'h02);

        repeat (3) pulse(1'b0, 1'b1);
        check("sat_low_0", {4'd0, num}, 8'h00);
        repeat (16) pulse(1'b1, 1'b0);
        check("p1_score_15", {4'd0, num}, 8'h0F);
        pulse(1'b1, 1'b0);
        check("sat_high_15", {4'd0, num}, 8'h0F);
        read_digit(0, seg); check("p1_tens_15", seg, 8'hF9);
        read_digit(1, seg); check("p1_ones_15", seg, 8'h92);

        // Align to the first cycle of digit 0, then each digit holds 2 cycles.
        read_digit(7, seg);
        read_digit(0, seg);
        exp_en = 8'hFE;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("scan_hold", seg_en, exp_en);
            tick(1);
            exp_en = {exp_en[6:0], exp_en[7]};
            check("scan_step", seg_en, exp_en);
        end

        select(4'b0010);
        ifCorrect = 1'b1;
        tick(1);
        rst = 1'b0;
        ifCorrect = 1'b0;
        tick(2);
        check("midrst_num", {4'd0, num}, 8'h00);
        check("midrst_seg_en", seg_en, 8'hFF);
        check("midrst_seg_out", seg_out, 8'hFF);
        rst = 1'b1;
        tick(4);
        check("midrst_p2_cleared", {4'd0, num}, 8'h00);
        select(4'b0001);
        check("midrst_p1_cleared", {4'd0, num}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
